// File: rtl/cc_mcu_bus_if_pkg.sv
// Shared definitions for the multiplexed MCU bus interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cc_mcu_bus_if_pkg;

    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_READ_HOLD = 2'd3
    } bus_state_t;

endpackage

// File: rtl/cc_input_sync.sv
// Multi-flop synchroniser for asynchronous inputs.
// Latency: STAGES clk cycles from pin to q.
// Backpressure: none; samples every cycle.
//
// Ports: clk, reset (async, active high), d (raw async input), q (synchronised).
// STAGES must be at least 2. Reset loads RESET_VALUE into every stage so the
// chain starts at the inactive level of the signal it carries.
module cc_input_sync #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VALUE;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cc_mcu_bus_if.sv
// Multiplexed-address/data MCU bus slave: turns async ALE/nRD/nWR into
// one-cycle register-file requests. Latency: request SYNC_STAGES+1 edges after
// the strobe falls. Backpressure: reads wait in READ_WAIT for rd_valid.
//
// Ports:
//   clk, reset            - system clock, async active-high reset
//   mcu_ale/nrd/nwr       - raw async MCU strobes (nrd/nwr active low)
//   mcu_ad_in/addr_hi     - multiplexed low byte and upper address from pins
//   mcu_ad_out/bus_sel_in - read data to pins and pin direction (1 = input)
//   addr, wr_data         - latched address and captured write data
//   wr_strobe, rd_strobe  - one-cycle requests to the register file
//   rd_data, rd_valid     - read response from the register file
module cc_mcu_bus_if
    import cc_mcu_bus_if_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mcu_ale,
    input  logic                         mcu_nrd,
    input  logic                         mcu_nwr,
    input  logic [DATA_WIDTH-1:0]        mcu_ad_in,
    input  logic [ADDR_WIDTH-DATA_WIDTH-1:0] mcu_addr_hi,
    output logic [DATA_WIDTH-1:0]        mcu_ad_out,
    output logic                         bus_sel_in,
    output logic [ADDR_WIDTH-1:0]        addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_strobe,
    output logic                         rd_strobe,
    input  logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         rd_valid
);

    // Cycles after reset release until the edge-detect registers hold real
    // pin history rather than reset values.
    localparam int FLUSH_CYCLES = SYNC_STAGES + 1;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 1);

    logic ale_s, nrd_s, nwr_s;
    logic nrd_q, nwr_q;
    logic nrd_fall, nwr_fall;
    logic [FLUSH_W-1:0] flush_cnt;
    logic flush_done;
    bus_state_t state;

    cc_input_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_ale (
        .clk(clk), .reset(reset), .d(mcu_ale), .q(ale_s)
    );
    cc_input_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_nrd (
        .clk(clk), .reset(reset), .d(mcu_nrd), .q(nrd_s)
    );
    cc_input_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_nwr (
        .clk(clk), .reset(reset), .d(mcu_nwr), .q(nwr_s)
    );

    // Edge-detect registers plus the post-reset flush counter. A strobe held
    // low through reset release would otherwise look like a fresh falling
    // edge once the inactive reset level drains out of the chain; edges are
    // only trusted once both the chain and the edge register carry samples
    // taken after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nrd_q     <= 1'b1;
            nwr_q     <= 1'b1;
            flush_cnt <= '0;
        end else begin
            nrd_q <= nrd_s;
            nwr_q <= nwr_s;
            if (!flush_done) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
        end
    end

    assign flush_done = (flush_cnt == FLUSH_W'(FLUSH_CYCLES));
    assign nrd_fall   = flush_done & nrd_q & ~nrd_s;
    assign nwr_fall   = flush_done & nwr_q & ~nwr_s;

    // Transaction FSM; all outputs are registered here. Edges seen outside
    // IDLE are single-cycle pulses, so they vanish rather than queue up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            wr_data    <= '0;
            mcu_ad_out <= '0;
            wr_strobe  <= 1'b0;
            rd_strobe  <= 1'b0;
            bus_sel_in <= 1'b1;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ale_s) begin
                        addr <= {mcu_addr_hi, mcu_ad_in};
                    end
                    // Write has priority: a simultaneous read is dropped.
                    if (nwr_fall) begin
                        wr_data   <= mcu_ad_in;
                        wr_strobe <= 1'b1;
                        state     <= ST_WRITE;
                    end else if (nrd_fall) begin
                        rd_strobe  <= 1'b1;
                        bus_sel_in <= 1'b0;
                        state      <= ST_READ_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (nwr_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    // MCU gave up before data arrived: release the pins and
                    // let any late rd_valid fall on the floor in IDLE.
                    if (nrd_s) begin
                        bus_sel_in <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (rd_valid) begin
                        mcu_ad_out <= rd_data;
                        state      <= ST_READ_HOLD;
                    end
                end
                ST_READ_HOLD: begin
                    if (nrd_s) begin
                        bus_sel_in <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    bus_sel_in <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cc_mcu_bus_if.md
CC_MCU_BUS_IF -- requirements
Module: cc_mcu_bus_if

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the width of the internal address.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of the multiplexed MCU address/data bus.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flip-flops per MCU strobe (minimum 2).

Ports:
REQ-004 The block SHALL have one clock, `clk`, input, 1 bit: the system clock; all state is updated on its rising edge.
REQ-005 The block SHALL have `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have `mcu_ale`, input, 1 bit: raw asynchronous address-latch enable from the MCU.
REQ-007 The block SHALL have `mcu_nrd`, input, 1 bit: raw asynchronous read strobe, active low.
REQ-008 The block SHALL have `mcu_nwr`, input, 1 bit: raw asynchronous write strobe, active low.
REQ-009 The block SHALL have `mcu_ad_in`, input, DATA_WIDTH bits: the low address/data byte, taken from the bidirectional pin input path.
REQ-010 The block SHALL have `mcu_addr_hi`, input, ADDR_WIDTH-DATA_WIDTH bits: the non-multiplexed upper address.
REQ-011 The block SHALL have `mcu_ad_out`, output, DATA_WIDTH bits: read data for the pin output path.
REQ-012 The block SHALL have `bus_sel_in`, output, 1 bit: pin direction, 1 = pins are inputs, 0 = the block drives the pins.
REQ-013 The block SHALL have `addr`, output, ADDR_WIDTH bits: the latched transaction address, fed to the address decoder.
REQ-014 The block SHALL have `wr_data`, output, DATA_WIDTH bits: captured write data.
REQ-015 The block SHALL have `wr_strobe`, output, 1 bit: one-cycle write request.
REQ-016 The block SHALL have `rd_strobe`, output, 1 bit: one-cycle read request.
REQ-017 The block SHALL have `rd_data`, input, DATA_WIDTH bits: read data from the register file.
REQ-018 The block SHALL have `rd_valid`, input, 1 bit: qualifies `rd_data`; it arrives 1 or more cycles after `rd_strobe`.

Function
REQ-019 The block SHALL pass each MCU strobe through a SYNC_STAGES flip-flop chain and then one edge-detect register.
  - Edges are detected only on the synchronised strobe values.
REQ-020 The block SHALL update `addr` in IDLE on every cycle in which synchronised ALE is 1.
  - The value loaded is {mcu_addr_hi, mcu_ad_in}.
  - `addr` SHALL hold its value in all other cycles and states.
REQ-021 The block SHALL implement the states IDLE, WRITE, READ_WAIT and READ_HOLD.
REQ-022 On a synchronised nWR falling edge in IDLE, the block SHALL:
  - capture mcu_ad_in into `wr_data`;
  - pulse `wr_strobe` for exactly one cycle;
  - enter WRITE.
  Latency: `wr_strobe` is high in the cycle after clock edge SYNC_STAGES+1, counting as edge 1 the first edge that samples mcu_nwr low.
REQ-023 WRITE SHALL return to IDLE when synchronised nWR is 1.
REQ-024 On a synchronised nRD falling edge in IDLE, the block SHALL:
  - pulse `rd_strobe` for exactly one cycle;
  - enter READ_WAIT;
  - set `bus_sel_in` to 0 on the same edge.
  Latency: identical to the write path.
REQ-025 In READ_WAIT, when `rd_valid` is 1, the block SHALL register `rd_data` into `mcu_ad_out` and enter READ_HOLD.
REQ-026 READ_HOLD SHALL hold `mcu_ad_out`, keep `bus_sel_in` at 0, and return to IDLE when synchronised nRD is 1.
  - `bus_sel_in` SHALL return to 1 on that same edge.
REQ-027 If synchronised nRD returns to 1 while in READ_WAIT, the block SHALL:
  - abort to IDLE;
  - set `bus_sel_in` to 1;
  - ignore any later `rd_valid`.
REQ-028 `rd_valid` SHALL be ignored in every state other than READ_WAIT.
REQ-029 If nRD and nWR fall in the same synchronised cycle, the write SHALL win.
  - The read SHALL be dropped, with no `rd_strobe`.
REQ-030 Strobe edges occurring outside IDLE SHALL be ignored.
  - No request is generated until the block is back in IDLE and a new falling edge occurs.
REQ-031 The block SHALL never assert `wr_strobe` and `rd_strobe` in the same cycle.

Reset
REQ-032 On `reset`, the block SHALL enter IDLE immediately.
  - Reset values: addr=0, wr_data=0, mcu_ad_out=0, wr_strobe=0, rd_strobe=0, bus_sel_in=1.
REQ-033 Reset SHALL load the synchroniser chains with inactive levels: ALE=0, nRD=1, nWR=1.
  - No edge SHALL be detected on reset release while the strobes are inactive.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction.
  - No strobe SHALL follow reset release unless a new falling edge occurs.

Structure
REQ-035 The state encodings and the default parameter values SHALL live in the shared package/header.
REQ-036 Each synchroniser chain SHALL be one sub-module, `cc_input_sync`, with parameters WIDTH, STAGES and RESET_VALUE.

Verification
REQ-037 Bench SHALL cover: write, ALE with addr_hi=0x12, ad=0x34, then nWR low with ad=0xA5 -> addr=0x1234, wr_data=0xA5, one `wr_strobe` at edge 3, no `rd_strobe`.
REQ-038 Bench SHALL cover: read, rd_valid returned 2 cycles after rd_strobe with rd_data=0x5C -> bus_sel_in=0 from strobe, mcu_ad_out=0x5C, bus_sel_in=1 two cycles after nRD rises.
REQ-039 Bench SHALL cover: abort, nRD released before rd_valid, then rd_valid pulsed -> IDLE, mcu_ad_out unchanged, bus_sel_in=1.
REQ-040 Bench SHALL cover: simultaneous fall, nRD and nWR low on the same edge with ad=0x77 -> one wr_strobe, wr_data=0x77, zero rd_strobe.
REQ-041 Bench SHALL cover: reset in READ_HOLD, with nRD held low through reset release -> bus_sel_in=1 immediately, outputs zeroed, no rd_strobe after release.
REQ-042 Bench SHALL cover: back-to-back writes, each separated by nWR high for SYNC_STAGES+1 cycles -> exactly one wr_strobe per write.
